// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/wait/execute control with branch, jump and register-jump redirects.
// Define DELAY_SLOT_EN to route taken redirects through one delay-slot instruction.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    output logic        inst_valid_out,
    input  logic        resolve_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        jump_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [15:0] imm16_in,
    input  logic [25:0] target26_in,
    output logic [31:0] pc_out,
    output logic [31:0] link_out,
    output logic        misalign_err_out
);

    typedef enum logic [1:0] {RST, FETCH, WAIT_MEM, EXECUTE} state_t;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFS = 32'd8;
`else
    localparam logic [31:0] LINK_OFS = 32'd4;
`endif

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic signed [31:0] br_off;
    logic [31:0]        target;
    logic [31:0]        npc;
    logic               taken;
    logic               misalign_hit;

`ifdef DELAY_SLOT_EN
    logic               pend_vld;
    logic [31:0]        pend_pc;
    logic               load_pend;
`endif

    assign pc4           = pc + 32'd4;
    assign br_off        = {{14{imm16_in[15]}}, imm16_in, 2'b00};
    assign pc_out        = pc;
    assign imem_addr_out = pc;

    always_comb begin
        taken        = resolve_in & (jump_in | branch_in);
        misalign_hit = resolve_in & jump_in & jump_reg_in & (alu_result_in[1:0] != 2'b00);
        target       = pc4;
        if (jump_in & jump_reg_in)
            target = {alu_result_in[31:2], 2'b00};
        else if (jump_in)
            target = {pc4[31:28], target26_in, 2'b00};
        else if (branch_in)
            target = pc4 + br_off;
`ifdef DELAY_SLOT_EN
        // Redirects resolved inside a delay slot are dropped; the pending target wins.
        load_pend = ~pend_vld & taken;
        npc       = pend_vld ? pend_pc : pc4;
        if (pend_vld)
            misalign_hit = 1'b0;
`else
        npc = taken ? target : pc4;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RST;
            pc               <= RESET_PC;
            link_out         <= RESET_PC + LINK_OFS;
            imem_req_out     <= 1'b0;
            inst_valid_out   <= 1'b0;
            misalign_err_out <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend_vld         <= 1'b0;
`endif
        end else begin
            case (state)
                RST: begin
                    state        <= FETCH;
                    imem_req_out <= 1'b1;
                end
                FETCH, WAIT_MEM: begin
                    if (imem_ready_in) begin
                        state          <= EXECUTE;
                        imem_req_out   <= 1'b0;
                        inst_valid_out <= 1'b1;
                    end else begin
                        state <= WAIT_MEM;
                    end
                end
                EXECUTE: begin
                    // A stalled instruction keeps every register, including resolution state.
                    if (!stall_in) begin
                        state          <= FETCH;
                        imem_req_out   <= 1'b1;
                        inst_valid_out <= 1'b0;
                        pc             <= npc;
                        link_out       <= npc + LINK_OFS;
                        if (misalign_hit)
                            misalign_err_out <= 1'b1;
`ifdef DELAY_SLOT_EN
                        pend_vld <= load_pend;
`endif
                    end
                end
                default: begin
                    state        <= RST;
                    imem_req_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAY_SLOT_EN
    // Target storage carries no reset; pend_vld qualifies it.
    always_ff @(posedge clk) begin
        if (state == EXECUTE && !stall_in && load_pend)
            pend_pc <= target;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, redirects, stalls, memory wait, reset abort, wrap.
// Expected values follow DELAY_SLOT_EN when the bench is built with it.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        inst_valid_out;
    logic        resolve_in;
    logic        branch_in;
    logic        jump_in;
    logic        jump_reg_in;
    logic [31:0] alu_result_in;
    logic [15:0] imm16_in;
    logic [25:0] target26_in;
    logic [31:0] pc_out;
    logic [31:0] link_out;
    logic        misalign_err_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ready_in    (imem_ready_in),
        .inst_valid_out   (inst_valid_out),
        .resolve_in       (resolve_in),
        .branch_in        (branch_in),
        .jump_in          (jump_in),
        .jump_reg_in      (jump_reg_in),
        .alu_result_in    (alu_result_in),
        .imm16_in         (imm16_in),
        .target26_in      (target26_in),
        .pc_out           (pc_out),
        .link_out         (link_out),
        .misalign_err_out (misalign_err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        resolve_in    = 1'b0;
        branch_in     = 1'b0;
        jump_in       = 1'b0;
        jump_reg_in   = 1'b0;
        alu_result_in = 32'h0;
        imm16_in      = 16'h0;
        target26_in   = 26'h0;
    endtask

    // Present resolution for the instruction in EXECUTE, then run to the next EXECUTE.
    task automatic issue(input logic res, input logic br, input logic jmp, input logic jr,
                         input logic [31:0] alu, input logic [15:0] imm, input logic [25:0] t26);
        int n;
        resolve_in    = res;
        branch_in     = br;
        jump_in       = jmp;
        jump_reg_in   = jr;
        alu_result_in = alu;
        imm16_in      = imm;
        target26_in   = t26;
        step();
        clear_ctl();
        n = 0;
        while (!inst_valid_out && n < 20) begin
            step();
            n++;
        end
        if (!inst_valid_out)
            check("exec_timeout", {31'b0, inst_valid_out}, 32'd1);
    endtask

    task automatic plain();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        issue(1'b1, 1'b0, 1'b1, 1'b1, addr, 16'h0, 26'h0);
`ifdef DELAY_SLOT_EN
        plain();
`endif
    endtask

    initial begin
        longint t0, t1;
        reset         = 1'b1;
        stall_in      = 1'b0;
        imem_ready_in = 1'b1;
        clear_ctl();
        step();
        step();
        check("rst_pc", pc_out, 32'h0040_0000);
        check("rst_req", {31'b0, imem_req_out}, 32'd0);
        check("rst_valid", {31'b0, inst_valid_out}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err_out}, 32'd0);

        reset = 1'b0;
        step();
        check("fetch0_req", {31'b0, imem_req_out}, 32'd1);
        check("fetch0_addr", imem_addr_out, 32'h0040_0000);
        check("fetch0_valid", {31'b0, inst_valid_out}, 32'd0);
        step();
        check("exec0_valid", {31'b0, inst_valid_out}, 32'd1);
        check("exec0_req", {31'b0, imem_req_out}, 32'd0);
        check("exec0_pc", pc_out, 32'h0040_0000);
        t0 = $time;
        plain();
        t1 = $time;
        check("seq_period", 32'((t1 - t0) / 10), 32'd2);
        check("seq_pc1", pc_out, 32'h0040_0004);
        plain();
        check("seq_pc2", pc_out, 32'h0040_0008);
`ifdef DELAY_SLOT_EN
        check("seq_link", link_out, 32'h0040_0010);
`else
        check("seq_link", link_out, 32'h0040_000C);
`endif

        // Backward branch of -4 words.
        goto_pc(32'h0040_0010);
        check("br_start", pc_out, 32'h0040_0010);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'hFFFC, 26'h0);
`ifdef DELAY_SLOT_EN
        check("br_slot", pc_out, 32'h0040_0014);
        plain();
`endif
        check("br_target", pc_out, 32'h0040_0004);

        // Direct jump with a simultaneous branch that must lose.
        goto_pc(32'h0040_0020);
`ifdef DELAY_SLOT_EN
        check("j_link", link_out, 32'h0040_0028);
`else
        check("j_link", link_out, 32'h0040_0024);
`endif
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0008, 26'h0100040);
`ifdef DELAY_SLOT_EN
        check("j_slot", pc_out, 32'h0040_0024);
        plain();
`endif
        check("j_target", pc_out, 32'h0040_0100);

        // Misaligned register jump.
        check("jr_pre_misalign", {31'b0, misalign_err_out}, 32'd0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0102, 16'h0010, 26'h0);
        check("jr_misalign", {31'b0, misalign_err_out}, 32'd1);
`ifdef DELAY_SLOT_EN
        plain();
`endif
        check("jr_target", pc_out, 32'h0040_0100);

        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0040, 26'h3FFFFFF);
        check("unresolved_pc4", pc_out, 32'h0040_0104);
        check("misalign_sticky", {31'b0, misalign_err_out}, 32'd1);

        // Two stalled EXECUTE cycles with live redirect inputs.
        stall_in      = 1'b1;
        resolve_in    = 1'b1;
        jump_in       = 1'b1;
        jump_reg_in   = 1'b1;
        alu_result_in = 32'h0040_0200;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_valid", {31'b0, inst_valid_out}, 32'd1);
            check("stall_pc", pc_out, 32'h0040_0104);
        end
        clear_ctl();
        stall_in = 1'b0;
        plain();
        check("post_stall_pc", pc_out, 32'h0040_0108);

        // Memory not ready for three cycles.
        imem_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wait_req", {31'b0, imem_req_out}, 32'd1);
            check("wait_addr", imem_addr_out, 32'h0040_010C);
        end
        imem_ready_in = 1'b1;
        step();
        check("wait_exec_valid", {31'b0, inst_valid_out}, 32'd1);
        check("wait_exec_req", {31'b0, imem_req_out}, 32'd0);
        check("wait_exec_pc", pc_out, 32'h0040_010C);

        // Reset pulse during WAIT_MEM.
        imem_ready_in = 1'b0;
        step();
        step();
        check("abort_wait_req", {31'b0, imem_req_out}, 32'd1);
        reset = 1'b1;
        step();
        check("abort_pc", pc_out, 32'h0040_0000);
        check("abort_req", {31'b0, imem_req_out}, 32'd0);
        check("abort_valid", {31'b0, inst_valid_out}, 32'd0);
        check("abort_misalign", {31'b0, misalign_err_out}, 32'd0);
        reset         = 1'b0;
        imem_ready_in = 1'b1;
        step();
        check("refetch_req", {31'b0, imem_req_out}, 32'd1);
        check("refetch_addr", imem_addr_out, 32'h0040_0000);
        step();
        check("refetch_valid", {31'b0, inst_valid_out}, 32'd1);

        // Address wrap at the top of the space.
        goto_pc(32'hFFFF_FFFC);
        check("wrap_start", pc_out, 32'hFFFF_FFFC);
`ifdef DELAY_SLOT_EN
        check("wrap_link", link_out, 32'h0000_0004);
`else
        check("wrap_link", link_out, 32'h0000_0000);
`endif
        plain();
        check("wrap_pc", pc_out, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
